// File: rtl/apb_manager_arb.sv
// apb_manager_arb: round-robin two-requester APB manager with ACCESS-phase timeout abort.
module apb_manager_arb #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic              req0_err,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic              req1_err,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t state, next;
  logic gnt, rr, pick, any, expire, fin, wr;
  logic [CW-1:0] cnt;
  // rr holds the port that wins the next tie, i.e. the one not granted last
  assign any    = req0_valid | req1_valid;
  assign pick   = (req0_valid & req1_valid) ? rr : req1_valid;
  assign wr     = pick ? req1_write : req0_write;
  assign expire = (TIMEOUT != 0) && !PREADY && (32'(cnt) + 1 >= TIMEOUT);
  assign fin    = (state == ACCESS) && (PREADY || expire);
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = any ? SETUP : IDLE;
      SETUP:   next = ACCESS;
      ACCESS:  next = fin ? DONE : ACCESS;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      rr         <= 1'b0;
      cnt        <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      req0_done  <= 1'b0;
      req0_err   <= 1'b0;
      req0_rdata <= '0;
      req1_done  <= 1'b0;
      req1_err   <= 1'b0;
      req1_rdata <= '0;
    end else begin
      state     <= next;
      PSEL      <= (next == SETUP) || (next == ACCESS);
      PENABLE   <= next == ACCESS;
      cnt       <= (state == ACCESS && !PREADY) ? cnt + 1'b1 : '0;
      req0_done <= fin && !gnt;
      req1_done <= fin && gnt;
      req0_err  <= fin && !gnt && expire;
      req1_err  <= fin && gnt && expire;
      if (state == IDLE && any) begin
        gnt    <= pick;
        rr     <= ~pick;
        PADDR  <= pick ? req1_addr : req0_addr;
        PWRITE <= wr;
        PWDATA <= wr ? (pick ? req1_wdata : req0_wdata) : '0;
      end
      // an abort clears rdata even for writes; a completed write leaves it alone
      if (fin && !gnt && (!PREADY || !PWRITE)) req0_rdata <= PREADY ? PRDATA : '0;
      if (fin && gnt && (!PREADY || !PWRITE)) req1_rdata <= PREADY ? PRDATA : '0;
    end
  end
endmodule

// File: tb/tb_apb_manager_arb.sv
// tb_apb_manager_arb: directed checks of arbitration, APB sequencing, timeout and async reset.
module tb_apb_manager_arb;
  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic        req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [3:0]  req0_addr = 0, req1_addr = 0;
  logic [31:0] req0_wdata = 0, req1_wdata = 0;
  logic        req0_done, req0_err, req1_done, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic [3:0]  PADDR;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PWDATA, PRDATA;
  logic        pready = 1'b0, stall = 1'b0;
  logic        u1_done0, u1_err0, u1_done1, u1_err1, u1_pwrite, u1_psel, u1_penable;
  logic [31:0] u1_rdata0, u1_rdata1, u1_pwdata;
  logic [3:0]  u1_paddr;
  logic [31:0] mem [4];
  int n_cmp = 0, n_err = 0, u1_dones = 0;
  int p, c;
  always #5 PCLK = ~PCLK;
  apb_manager_arb #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(15)) u0 (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_done(req0_done), .req0_err(req0_err), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_done(req1_done), .req1_err(req1_err), .req1_rdata(req1_rdata),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(pready));
  // second instance with timeout disabled and a completer that never answers
  apb_manager_arb #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(0)) u1 (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_done(u1_done0), .req0_err(u1_err0), .req0_rdata(u1_rdata0),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_done(u1_done1), .req1_err(u1_err1), .req1_rdata(u1_rdata1),
    .PADDR(u1_paddr), .PWRITE(u1_pwrite), .PSEL(u1_psel), .PENABLE(u1_penable), .PWDATA(u1_pwdata),
    .PRDATA(32'h0), .PREADY(1'b0));
  assign PRDATA = mem[PADDR[3:2]];
  always @(posedge PCLK) begin
    pready <= !stall && PSEL && PENABLE && !pready;
    if (PSEL && PENABLE && pready && PWRITE) mem[PADDR[3:2]] <= PWDATA;
    if (u1_done0 || u1_done1) u1_dones <= u1_dones + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int port, output int cyc);
    port = -1;
    cyc = 0;
    while (cyc < 200 && port < 0) begin
      @(negedge PCLK);
      cyc++;
      if (req0_done) port = 0;
      else if (req1_done) port = 1;
    end
  endtask
  initial begin
    repeat (2) @(negedge PCLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_done0", req0_done, 0);
    chk("rst_rdata1", req1_rdata, 0);
    PRESET = 0;
    // single write, cycle by cycle
    req0_valid = 1; req0_write = 1; req0_addr = 4'h8; req0_wdata = 32'hDEADBEEF;
    @(negedge PCLK);
    chk("t1_c1_psel", PSEL, 1);
    chk("t1_c1_penable", PENABLE, 0);
    chk("t1_c1_paddr", PADDR, 4'h8);
    chk("t1_c1_pwdata", PWDATA, 32'hDEADBEEF);
    req0_wdata = 32'h12345678;
    @(negedge PCLK);
    chk("t1_c2_penable", PENABLE, 1);
    chk("t1_c2_pwdata", PWDATA, 32'hDEADBEEF);
    @(negedge PCLK);
    chk("t1_c3_penable", PENABLE, 1);
    chk("t1_c3_done0", req0_done, 0);
    @(negedge PCLK);
    chk("t1_c4_done0", req0_done, 1);
    chk("t1_c4_err0", req0_err, 0);
    chk("t1_c4_psel", PSEL, 0);
    chk("t1_c4_rdata0", req0_rdata, 0);
    req0_valid = 0;
    @(negedge PCLK);
    chk("t1_c5_done0", req0_done, 0);
    // read back; write data must be zeroed on the bus
    req0_valid = 1; req0_write = 0; req0_addr = 4'h8; req0_wdata = 32'hFFFFFFFF;
    @(negedge PCLK);
    chk("t1r_pwdata", PWDATA, 0);
    chk("t1r_pwrite", PWRITE, 0);
    wait_done(p, c);
    chk("t1r_port", 32'(p), 0);
    chk("t1r_cyc", 32'(c), 3);
    chk("t1r_rdata0", req0_rdata, 32'hDEADBEEF);
    req0_valid = 0;
    // simultaneous requests right after reset
    PRESET = 1;
    @(negedge PCLK);
    chk("t2_rst_rdata0", req0_rdata, 0);
    PRESET = 0;
    req0_valid = 1; req0_write = 1; req0_addr = 4'h4; req0_wdata = 32'h11111111;
    req1_valid = 1; req1_write = 1; req1_addr = 4'hC; req1_wdata = 32'h22222222;
    wait_done(p, c);
    chk("t2_first_port", 32'(p), 0);
    chk("t2_first_cyc", 32'(c), 4);
    req0_valid = 0;
    wait_done(p, c);
    chk("t2_second_port", 32'(p), 1);
    chk("t2_second_cyc", 32'(c), 5);
    req1_valid = 0;
    @(negedge PCLK);
    // sustained contention: port 0 writes, port 1 reads back 0x4
    req0_valid = 1; req0_write = 1; req0_addr = 4'h0;
    req1_valid = 1; req1_write = 0; req1_addr = 4'h4;
    for (int k = 0; k < 6; k++) begin
      req0_wdata = 32'(k);
      wait_done(p, c);
      chk("t3_port", 32'(p), 32'(k % 2));
      if (p == 1) chk("t3_rdata1", req1_rdata, 32'h11111111);
      if (p == 0) req0_valid = 0; else req1_valid = 0;
      @(negedge PCLK);
      chk("t3_done_pulse", (p == 0) ? req0_done : req1_done, 0);
      req0_valid = 1; req1_valid = 1;
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge PCLK);
    // port 1 read leaves port 0 rdata alone
    req0_valid = 1; req0_write = 0; req0_addr = 4'h8;
    wait_done(p, c);
    chk("t6_p0_port", 32'(p), 0);
    chk("t6_p0_rdata", req0_rdata, 32'hDEADBEEF);
    req0_valid = 0;
    @(negedge PCLK);
    req1_valid = 1; req1_write = 0; req1_addr = 4'hC;
    wait_done(p, c);
    chk("t6_p1_port", 32'(p), 1);
    chk("t6_p1_rdata", req1_rdata, 32'h22222222);
    chk("t6_p0_kept", req0_rdata, 32'hDEADBEEF);
    req1_valid = 0;
    @(negedge PCLK);
    // timeout abort after 15 stalled ACCESS cycles
    stall = 1;
    req0_valid = 1; req0_write = 0; req0_addr = 4'h8;
    wait_done(p, c);
    chk("t4_port", 32'(p), 0);
    chk("t4_cyc", 32'(c), 17);
    chk("t4_err0", req0_err, 1);
    chk("t4_rdata0", req0_rdata, 0);
    chk("t4_psel", PSEL, 0);
    req0_valid = 0;
    stall = 0;
    @(negedge PCLK);
    chk("t4_err_clear", req0_err, 0);
    // timeout disabled: u1 has been stalled in ACCESS since its last reset
    repeat (100) @(negedge PCLK);
    chk("t5_no_done", 32'(u1_dones), 0);
    chk("t5_penable", u1_penable, 1);
    // async reset in the middle of ACCESS
    req0_valid = 1; req0_write = 1; req0_addr = 4'h0; req0_wdata = 32'h5;
    repeat (2) @(negedge PCLK);
    chk("t7_penable", PENABLE, 1);
    req1_valid = 1; req1_write = 0; req1_addr = 4'h4;
    #2 PRESET = 1;
    #1;
    chk("t7_psel", PSEL, 0);
    chk("t7_penable_rst", PENABLE, 0);
    chk("t7_done0", req0_done, 0);
    req0_valid = 0;
    @(negedge PCLK);
    PRESET = 0;
    wait_done(p, c);
    chk("t7_port", 32'(p), 1);
    chk("t7_cyc", 32'(c), 4);
    chk("t7_rdata1", req1_rdata, 32'h11111111);
    req1_valid = 0;
    @(negedge PCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
